// File: rtl/fifo_sync.sv
// ============================================================================
// Module   : fifo_sync
// Brief    : Single-clock FIFO with occupancy count, threshold flags, sticky
//            error flags and selectable standard / first-word-fall-through read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_sync #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 4,
    parameter int AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  w_push,
    output logic                  w_full,
    output logic                  w_almost_full,
    output logic                  w_overflow,
    input  logic                  r_pop,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_empty,
    output logic                  r_almost_empty,
    output logic                  r_underflow,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int                  c_DEPTH_INT = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_DEPTH     = c_DEPTH_INT[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] c_AF_THRESH = AF_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] c_AE_THRESH = AE_THRESH[ADDR_WIDTH:0];

    generate
        if (ADDR_WIDTH < 1 || DATA_WIDTH < 1 || (FWFT != 0 && FWFT != 1) ||
            AF_THRESH < 1 || AF_THRESH > c_DEPTH_INT ||
            AE_THRESH < 0 || AE_THRESH > c_DEPTH_INT - 1) begin : g_cfg_error
            $error("fifo_sync: illegal parameter configuration");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH_INT];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow_flag;

    logic w_push_acc;
    logic w_pop_acc;

    // Flags come straight from the registered count so they are glitch-free.
    assign w_full         = (r_count == c_DEPTH);
    assign r_empty        = (r_count == '0);
    assign w_almost_full  = (r_count >= c_AF_THRESH);
    assign r_almost_empty = (r_count <= c_AE_THRESH);
    assign w_overflow     = r_overflow;
    assign r_underflow    = r_underflow_flag;
    assign count          = r_count;

    assign w_push_acc = w_push & ~w_full;
    assign w_pop_acc  = r_pop & ~r_empty;

    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_overflow       <= 1'b0;
            r_underflow_flag <= 1'b0;
        end else if (flush) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_overflow       <= 1'b0;
            r_underflow_flag <= 1'b0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full) begin
                r_overflow <= 1'b1;
            end
            if (r_pop && r_empty) begin
                r_underflow_flag <= 1'b1;
            end
        end
    end

    generate
        if (FWFT == 0) begin : g_std_read
            logic [DATA_WIDTH-1:0] r_rdata;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rdata <= '0;
                end else if (flush) begin
                    r_rdata <= '0;
                end else if (w_pop_acc) begin
                    r_rdata <= r_mem[r_rd_ptr];
                end
            end

            assign r_data = r_rdata;
        end else begin : g_fwft_read
            // Head word is visible while the FIFO holds data; zero when empty.
            assign r_data = r_empty ? '0 : r_mem[r_rd_ptr];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fifo_sync.sv
// ============================================================================
// Module   : tb_fifo_sync
// Brief    : Directed self-checking bench for fifo_sync (standard and FWFT).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_sync;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [7:0] w_data;
    logic       w_push;
    logic       r_pop;

    logic       full_s, afull_s, ovf_s, empty_s, aempty_s, unf_s;
    logic [7:0] rdata_s;
    logic [5:0] count_s;
    logic       full_f, afull_f, ovf_f, empty_f, aempty_f, unf_f;
    logic [7:0] rdata_f;
    logic [5:0] count_f;

    int checks;
    int failures;

    fifo_sync #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .FWFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .w_data(w_data), .w_push(w_push), .w_full(full_s),
        .w_almost_full(afull_s), .w_overflow(ovf_s),
        .r_pop(r_pop), .r_data(rdata_s), .r_empty(empty_s),
        .r_almost_empty(aempty_s), .r_underflow(unf_s), .count(count_s)
    );

    fifo_sync #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .FWFT(1)) dut_f (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .w_data(w_data), .w_push(w_push), .w_full(full_f),
        .w_almost_full(afull_f), .w_overflow(ovf_f),
        .r_pop(r_pop), .r_data(rdata_f), .r_empty(empty_f),
        .r_almost_empty(aempty_f), .r_underflow(unf_f), .count(count_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic cyc(input logic p, input logic [7:0] d, input logic q);
        w_push = p;
        w_data = d;
        r_pop  = q;
        @(posedge clk);
        #1;
        w_push = 1'b0;
        r_pop  = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (count_s !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_s); end
        checks++; if ({full_s, afull_s, ovf_s, unf_s} !== 4'b0000) begin failures++; $display("FAIL reset_wflags got=%b exp=0000", {full_s, afull_s, ovf_s, unf_s}); end
        checks++; if ({empty_s, aempty_s} !== 2'b11) begin failures++; $display("FAIL reset_rflags got=%b exp=11", {empty_s, aempty_s}); end
        checks++; if (rdata_s !== 8'h00 || rdata_f !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=00/00", rdata_s, rdata_f); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp_f;
        for (int i = 1; i <= 32; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
            checks++; if (count_s !== 6'(i)) begin failures++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count_s, i); end
            checks++; if (afull_s !== (i >= 28) || full_s !== (i == 32) || aempty_s !== (i <= 4)) begin
                failures++; $display("FAIL fill_flags i=%0d got af=%b f=%b ae=%b", i, afull_s, full_s, aempty_s);
            end
            if (i == 1) begin
                checks++; if (rdata_f !== 8'h01 || rdata_s !== 8'h00) begin failures++; $display("FAIL fill_first_rdata got=%h/%h exp=00/01", rdata_s, rdata_f); end
            end
        end
        for (int k = 1; k <= 32; k++) begin
            cyc(1'b0, 8'h00, 1'b1);
            exp_f = (k < 32) ? 8'(k + 1) : 8'h00;
            checks++; if (rdata_s !== 8'(k)) begin failures++; $display("FAIL drain_rdata k=%0d got=%h exp=%h", k, rdata_s, 8'(k)); end
            checks++; if (rdata_f !== exp_f) begin failures++; $display("FAIL drain_fwft k=%0d got=%h exp=%h", k, rdata_f, exp_f); end
        end
        checks++; if (empty_s !== 1'b1 || count_s !== 6'd0) begin failures++; $display("FAIL drain_empty got e=%b c=%0d exp e=1 c=0", empty_s, count_s); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 32; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
        cyc(1'b1, 8'hAA, 1'b0);
        checks++; if (ovf_s !== 1'b1 || count_s !== 6'd32) begin failures++; $display("FAIL ovf_set got o=%b c=%0d exp o=1 c=32", ovf_s, count_s); end
        for (int i = 0; i < 32; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            checks++; if (rdata_s !== 8'(8'h40 + i)) begin failures++; $display("FAIL ovf_drain i=%0d got=%h exp=%h", i, rdata_s, 8'(8'h40 + i)); end
        end
        checks++; if (empty_s !== 1'b1 || ovf_s !== 1'b1) begin failures++; $display("FAIL ovf_end got e=%b o=%b exp e=1 o=1", empty_s, ovf_s); end
        do_flush();
        checks++; if (ovf_s !== 1'b0) begin failures++; $display("FAIL ovf_flush got=%b exp=0", ovf_s); end
    endtask

    task automatic test_simul();
        cyc(1'b1, 8'h11, 1'b1);
        checks++; if (count_s !== 6'd1 || unf_s !== 1'b1) begin failures++; $display("FAIL simul_empty got c=%0d u=%b exp c=1 u=1", count_s, unf_s); end
        cyc(1'b0, 8'h00, 1'b1);
        checks++; if (rdata_s !== 8'h11) begin failures++; $display("FAIL simul_empty_rd got=%h exp=11", rdata_s); end
        do_flush();
        for (int i = 0; i < 32; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0);
        cyc(1'b1, 8'h99, 1'b1);
        checks++; if (count_s !== 6'd31 || ovf_s !== 1'b1) begin failures++; $display("FAIL simul_full got c=%0d o=%b exp c=31 o=1", count_s, ovf_s); end
        checks++; if (rdata_s !== 8'h60) begin failures++; $display("FAIL simul_full_rd got=%h exp=60", rdata_s); end
        do_flush();
    endtask

    task automatic test_fwft();
        cyc(1'b1, 8'h5A, 1'b0);
        checks++; if (rdata_f !== 8'h5A || empty_f !== 1'b0) begin failures++; $display("FAIL fwft_push got d=%h e=%b exp d=5a e=0", rdata_f, empty_f); end
        checks++; if (rdata_s !== 8'h00) begin failures++; $display("FAIL fwft_std_hold got=%h exp=00", rdata_s); end
        cyc(1'b0, 8'h00, 1'b0);
        checks++; if (rdata_f !== 8'h5A) begin failures++; $display("FAIL fwft_idle got=%h exp=5a", rdata_f); end
        cyc(1'b0, 8'h00, 1'b1);
        checks++; if (rdata_f !== 8'h00 || empty_f !== 1'b1) begin failures++; $display("FAIL fwft_pop got d=%h e=%b exp d=00 e=1", rdata_f, empty_f); end
        checks++; if (rdata_s !== 8'h5A) begin failures++; $display("FAIL fwft_std_pop got=%h exp=5a", rdata_s); end
        do_flush();
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        int pushed;
        pushed = 0;
        for (int c = 0; c < 600 && (pushed < 100 || q.size() > 0); c++) begin
            logic       p;
            logic       po;
            logic [7:0] d;
            logic [7:0] exp_d;
            p     = (pushed < 100) && (c % 4 < 2) && (q.size() < 32);
            po    = ((c % 4 == 1) || (c % 4 == 2) || (pushed >= 100)) && (q.size() > 0);
            d     = 8'(pushed * 7 + 3);
            exp_d = 8'h00;
            if (po) exp_d = q.pop_front();
            if (p) begin
                q.push_back(d);
                pushed++;
            end
            cyc(p, d, po);
            checks++; if (count_s !== 6'(q.size())) begin failures++; $display("FAIL wrap_count c=%0d got=%0d exp=%0d", c, count_s, q.size()); end
            if (po) begin
                checks++; if (rdata_s !== exp_d) begin failures++; $display("FAIL wrap_data c=%0d got=%h exp=%h", c, rdata_s, exp_d); end
            end
        end
        checks++; if ({empty_s, full_s, ovf_s, unf_s} !== 4'b1000) begin failures++; $display("FAIL wrap_flags got=%b exp=1000", {empty_s, full_s, ovf_s, unf_s}); end
    endtask

    task automatic test_flush();
        cyc(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 32; i++) cyc(1'b1, 8'(i), 1'b0);
        cyc(1'b1, 8'hEE, 1'b0);
        for (int i = 0; i < 22; i++) cyc(1'b0, 8'h00, 1'b1);
        checks++; if (count_s !== 6'd10 || ovf_s !== 1'b1 || unf_s !== 1'b1) begin
            failures++; $display("FAIL flush_pre got c=%0d o=%b u=%b exp c=10 o=1 u=1", count_s, ovf_s, unf_s);
        end
        flush  = 1'b1;
        w_push = 1'b1;
        w_data = 8'h77;
        @(posedge clk);
        #1;
        flush  = 1'b0;
        w_push = 1'b0;
        checks++; if (count_s !== 6'd0 || empty_s !== 1'b1) begin failures++; $display("FAIL flush_count got c=%0d e=%b exp c=0 e=1", count_s, empty_s); end
        checks++; if ({ovf_s, unf_s, full_s, afull_s} !== 4'b0000) begin failures++; $display("FAIL flush_flags got=%b exp=0000", {ovf_s, unf_s, full_s, afull_s}); end
        checks++; if (rdata_s !== 8'h00) begin failures++; $display("FAIL flush_rdata got=%h exp=00", rdata_s); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h71 + i), 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        checks++; if (rdata_s !== 8'h71) begin failures++; $display("FAIL arst_pre got=%h exp=71", rdata_s); end
        w_push = 1'b1;
        w_data = 8'hCC;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (count_s !== 6'd0 || empty_s !== 1'b1 || aempty_s !== 1'b1) begin
            failures++; $display("FAIL arst_count got c=%0d e=%b ae=%b exp c=0 e=1 ae=1", count_s, empty_s, aempty_s);
        end
        checks++; if (rdata_s !== 8'h00 || rdata_f !== 8'h00) begin failures++; $display("FAIL arst_rdata got=%h/%h exp=00/00", rdata_s, rdata_f); end
        @(posedge clk);
        #1;
        checks++; if (count_s !== 6'd0) begin failures++; $display("FAIL arst_hold got=%0d exp=0", count_s); end
        w_push = 1'b0;
        rst_n  = 1'b1;
        cyc(1'b1, 8'h33, 1'b0);
        checks++; if (count_s !== 6'd1) begin failures++; $display("FAIL arst_first_push got=%0d exp=1", count_s); end
        cyc(1'b0, 8'h00, 1'b1);
        checks++; if (rdata_s !== 8'h33) begin failures++; $display("FAIL arst_after_rd got=%h exp=33", rdata_s); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        w_push   = 1'b0;
        r_pop    = 1'b0;
        w_data   = 8'h00;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_simul();
        test_fwft();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
